// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx between NUM_REQ byte producers.
// Frame timing is generated locally because uart_tx gives no busy/done signal.
module uart_tx_arbiter #(
   parameter int NUM_REQ         = 4,
   parameter int CLKS_PER_BIT    = 434,
   parameter int FRAME_BITS      = 10,
   parameter int SEND_PULSE_CLKS = 10,
   parameter int GAP_CLKS        = 434,
   localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_i,
   input  logic [NUM_REQ*8-1:0] data_i,
   output logic [NUM_REQ-1:0]   ack_o,
   output logic                 busy_o,
   output logic [GW-1:0]        grant_id_o,
   output logic                 tx_send_o,
   output logic [7:0]           tx_data_o
);

   localparam int FRAME_CLKS = FRAME_BITS * CLKS_PER_BIT;
   localparam int MAX_A = (SEND_PULSE_CLKS > FRAME_CLKS) ? SEND_PULSE_CLKS : FRAME_CLKS;
   localparam int MAXC  = (MAX_A > GAP_CLKS) ? MAX_A : GAP_CLKS;
   localparam int CW    = (MAXC > 1) ? $clog2(MAXC + 1) : 1;
   localparam int SEND_LOAD  = SEND_PULSE_CLKS - 1;
   localparam int FRAME_LOAD = FRAME_CLKS - 1;
   localparam int GAP_LOAD   = (GAP_CLKS > 0) ? GAP_CLKS - 1 : 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND  = 2'd1,
      FRAME = 2'd2,
      GAP   = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [GW-1:0]   ptr_q, ptr_d;
   logic [GW-1:0]   grant_q, grant_d;
   logic [7:0]      data_q, data_d;

   logic            found;
   logic [GW-1:0]   gsel;
   int              idx;

   // Round-robin search starting at the pointer
   always_comb begin
      found = 1'b0;
      gsel  = '0;
      idx   = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = (int'(ptr_q) + i) % NUM_REQ;
         if (!found && req_i[idx]) begin
            found = 1'b1;
            gsel  = GW'(idx);
         end
      end
   end

   // Next-state, counter and latched-output logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      data_d  = data_q;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               grant_d = gsel;
               data_d  = data_i[8*int'(gsel) +: 8];
               if (int'(gsel) == NUM_REQ - 1) ptr_d = '0;
               else                           ptr_d = gsel + GW'(1);
               cnt_d   = CW'(SEND_LOAD);
               state_d = SEND;
            end
         end
         SEND: begin
            if (cnt_q == '0) begin
               cnt_d   = CW'(FRAME_LOAD);
               state_d = FRAME;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         FRAME: begin
            if (cnt_q == '0) begin
               if (GAP_CLKS > 0) begin
                  cnt_d   = CW'(GAP_LOAD);
                  state_d = GAP;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         GAP: begin
            if (cnt_q == '0) state_d = IDLE;
            else             cnt_d   = cnt_q - CW'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   // State register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ptr_q   <= '0;
         grant_q <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         data_q  <= data_d;
      end
   end

   // Outputs decoded from state; ack in the last frame cycle
   always_comb begin
      ack_o = '0;
      if (state_q == FRAME && cnt_q == '0) ack_o[grant_q] = 1'b1;
      busy_o     = (state_q != IDLE);
      tx_send_o  = (state_q == SEND);
      grant_id_o = grant_q;
      tx_data_o  = data_q;
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: table of single-byte transactions plus
// hand-written sequences for withdrawal, mid-frame reset and no-gap streaming.
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req0 = '0;
   logic [31:0] data0 = '0;
   logic [3:0]  ack0;
   logic        busy0;
   logic [1:0]  gid0;
   logic        send0;
   logic [7:0]  txd0;

   logic        req1 = 1'b0;
   logic [7:0]  data1 = '0;
   logic        ack1;
   logic        busy1;
   logic        gid1;
   logic        send1;
   logic [7:0]  txd1;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .NUM_REQ(4), .CLKS_PER_BIT(4), .FRAME_BITS(10),
      .SEND_PULSE_CLKS(2), .GAP_CLKS(4)
   ) u0 (
      .clk(clk), .rst(rst), .req_i(req0), .data_i(data0),
      .ack_o(ack0), .busy_o(busy0), .grant_id_o(gid0),
      .tx_send_o(send0), .tx_data_o(txd0)
   );

   uart_tx_arbiter #(
      .NUM_REQ(1), .CLKS_PER_BIT(4), .FRAME_BITS(10),
      .SEND_PULSE_CLKS(2), .GAP_CLKS(0)
   ) u1 (
      .clk(clk), .rst(rst), .req_i(req1), .data_i(data1),
      .ack_o(ack1), .busy_o(busy1), .grant_id_o(gid1),
      .tx_send_o(send1), .tx_data_o(txd1)
   );

   typedef struct {
      logic        rst;
      logic [3:0]  rq;
      logic [3:0]  rq_after;
      logic [31:0] dat;
      logic [1:0]  eg;
      logic [7:0]  eb;
   } vec_t;

   vec_t tbl[9];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst  = 1'b1;
      req0 = '0;
      req1 = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_ack", 32'(ack0), 0);
      chk("rst_busy", 32'(busy0), 0);
      chk("rst_gid", 32'(gid0), 0);
      chk("rst_send", 32'(send0), 0);
      chk("rst_data", 32'(txd0), 0);
   endtask

   // Called at a negedge with the DUT idle; returns at the next idle cycle
   task automatic do_txn(input logic [3:0] rq, input logic [3:0] rq_after,
                         input logic [31:0] dat, input logic [1:0] eg,
                         input logic [7:0] eb, input logic [3:0] pulse,
                         input string nm);
      logic [3:0] eack;
      eack  = 4'b0001 << eg;
      req0  = rq;
      data0 = dat;
      for (int n = 1; n <= 47; n++) begin
         @(negedge clk);
         if (n == 1) begin
            chk($sformatf("%s_gid", nm), 32'(gid0), 32'(eg));
            chk($sformatf("%s_data", nm), 32'(txd0), 32'(eb));
         end
         chk($sformatf("%s_send n=%0d", nm, n), 32'(send0), 32'(n <= 2));
         chk($sformatf("%s_ack n=%0d", nm, n), 32'(ack0),
             (n == 42) ? 32'(eack) : 32'd0);
         chk($sformatf("%s_busy n=%0d", nm, n), 32'(busy0), 32'(n <= 46));
         if (n >= 10 && n <= 14) req0 = rq | pulse;
         if (n == 15) req0 = rq;
         if (n == 42) req0 = rq_after;
      end
      chk($sformatf("%s_hold", nm), 32'(txd0), 32'(eb));
   endtask

   int acks[$];

   initial begin
      tbl[0] = '{1'b1, 4'b0001, 4'b0000, 32'h00000055, 2'd0, 8'h55};
      tbl[1] = '{1'b1, 4'b1111, 4'b1110, 32'h04030201, 2'd0, 8'h01};
      tbl[2] = '{1'b0, 4'b1110, 4'b1100, 32'h04030201, 2'd1, 8'h02};
      tbl[3] = '{1'b0, 4'b1100, 4'b1000, 32'h04030201, 2'd2, 8'h03};
      tbl[4] = '{1'b0, 4'b1000, 4'b0000, 32'h04030201, 2'd3, 8'h04};
      tbl[5] = '{1'b0, 4'b0101, 4'b0101, 32'hD4C3B2A1, 2'd0, 8'hA1};
      tbl[6] = '{1'b0, 4'b0101, 4'b0101, 32'hD4C3B2A1, 2'd2, 8'hC3};
      tbl[7] = '{1'b0, 4'b0101, 4'b0101, 32'hD4C3B2A1, 2'd0, 8'hA1};
      tbl[8] = '{1'b0, 4'b0101, 4'b0000, 32'hD4C3B2A1, 2'd2, 8'hC3};

      repeat (2) @(negedge clk);

      for (int i = 0; i < 9; i++) begin
         if (tbl[i].rst) do_reset();
         do_txn(tbl[i].rq, tbl[i].rq_after, tbl[i].dat, tbl[i].eg,
                tbl[i].eb, 4'b0000, $sformatf("vec%0d", i));
      end

      // Request 1 pulsed during byte 0's frame is never served
      do_txn(4'b0001, 4'b0000, 32'h0000003C, 2'd0, 8'h3C, 4'b0010, "wdraw");
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         chk("wdraw_idle_ack", 32'(ack0), 0);
         chk("wdraw_idle_busy", 32'(busy0), 0);
      end

      // Reset in the middle of a frame
      req0  = 4'b0001;
      data0 = 32'h000000A5;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (n == 1) chk("mrst_gid", 32'(gid0), 0);
      end
      rst  = 1'b1;
      req0 = '0;
      @(negedge clk);
      rst = 1'b0;
      chk("mrst_ack", 32'(ack0), 0);
      chk("mrst_busy", 32'(busy0), 0);
      chk("mrst_gid", 32'(gid0), 0);
      chk("mrst_send", 32'(send0), 0);
      chk("mrst_data", 32'(txd0), 0);
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         chk("mrst_noack", 32'(ack0), 0);
      end
      do_txn(4'b1000, 4'b0000, 32'h5A000000, 2'd3, 8'h5A, 4'b0000, "mrst_r3");

      // Single requester streaming with no guard gap
      req1  = 1'b1;
      data1 = 8'h77;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         if (acks.size() > 0 && acks[$] == c - 1) begin
            chk("ng_idle_busy", 32'(busy1), 0);
            chk("ng_idle_send", 32'(send1), 0);
         end
         if (acks.size() > 0 && acks[$] == c - 2)
            chk("ng_resend", 32'(send1), 1);
         if (ack1) begin
            chk("ng_data", 32'(txd1), 32'h77);
            acks.push_back(c);
         end
      end
      req1 = 1'b0;
      chk("ng_ack_cnt", 32'(acks.size() >= 4), 1);
      if (acks.size() > 0) chk("ng_first", 32'(acks[0]), 42);
      for (int k = 1; k < acks.size(); k++)
         chk("ng_spacing", 32'(acks[k] - acks[k-1]), 43);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
